lfsr_delay_gen: RTL and testbench
=================================

// Module: lfsr_delay_gen
// PURPOSE
//  Pseudo-random pre-start delay generator for the reaction-timer game.
//  Takes a start pulse from the game FSM when it leaves HI_SCORE, draws a
//  random delay from a free-running LFSR and counts it down in 1 ms ticks.
//  It then asserts delay_ready, which drives the FSM's DELAYING->TIMING
//  transition and the "go" LED.
// PARAMETERS
//  TICK_DIV    50000    clocks per 1 ms tick (50 MHz / 1 kHz)
//  SEED        16'hACE1 LFSR reset value; must be non-zero
//  MIN_MS      1000     fixed delay floor, ms
//  RANGE_BITS  12       LFSR bits added to floor (0..2^RANGE_BITS-1 ms)
//  CNT_W       13       width of delay_ms / down-counter; holds MIN_MS+2^RANGE_BITS-1
// PORTS
//  MAX10_CLK1_50  in   1      system clock, all logic on posedge
//  reset          in   1      synchronous, active-high
//  start          in   1      1-cycle pulse: draw and start a new delay
//  abort          in   1      level/pulse: cancel delay (KEY[1] press, SW[9] GO_BUFFS)
//  delay_ready    out  1      high from delay expiry until start/abort/reset
//  busy           out  1      high while counting down
//  delay_ms       out  CNT_W  delay (ms) drawn at last accepted start
//  lfsr_q         out  16     current LFSR state (debug/LEDs)
// BEHAVIOUR
//  Reset (sync, overrides all): state=IDLE, lfsr=SEED, prescaler=0, count=0;
//   delay_ready=0, busy=0, delay_ms=0.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11; shifts every clock in every state
//   (entropy comes from player press timing). If the state reads 0, it reloads SEED
//   next cycle.
//  Draw: D = MIN_MS + lfsr[RANGE_BITS-1:0], using the LFSR value on the start edge.
//   D is zero-extended to CNT_W. D>=1 is guaranteed by MIN_MS>=1.
//  FSM states: IDLE, COUNT, READY.
//   IDLE : start -> load count=D, delay_ms=D, prescaler=0, go COUNT.
//   COUNT: busy=1. prescaler counts 0..TICK_DIV-1 and wraps. tick=1 when
//          prescaler==TICK_DIV-1. On tick, count--. A tick with count==1 moves
//          to READY. start is ignored in COUNT. abort -> IDLE; delay_ms is held.
//   READY: delay_ready=1, busy=0. abort -> IDLE. start -> reload as from IDLE.
//  Priority: reset > abort > start > tick. abort and start in the same cycle
//   -> IDLE with no load.
//  Latency: start sampled at edge t -> busy=1 after edge t. delay_ready=1 after
//   edge t + D*TICK_DIV, i.e. exactly D*TICK_DIV clocks after start.
//  Outputs are registered or decoded from state only. No combinational start->output path.
//  Reset mid-COUNT: returns to IDLE and SEED; no delay_ready pulse.
// TESTING (bench overrides: TICK_DIV=4, MIN_MS=2, RANGE_BITS=2, SEED=16'hACE1)
//  1 Reset 3 clks -> delay_ready=0, busy=0, delay_ms=0, lfsr_q=16'hACE1.
//    Free-run 5 clks -> lfsr_q follows the golden LFSR model.
//  2 Pulse start when lfsr[1:0]=2'b01 -> delay_ms=3. busy high 12 clks.
//    delay_ready rises exactly 12 clks after the start edge and holds.
//  3 In COUNT, pulse start again mid-delay -> ignored. delay_ms unchanged and
//    expiry timing unchanged.
//  4 abort 5 clks after start -> IDLE next clk, busy=0. delay_ready never
//    asserts. delay_ms keeps the last value.
//  5 In READY, assert start and abort together -> IDLE, delay_ready=0, no reload.
//    Then start alone -> new D loaded, busy=1.
//  6 Assert reset mid-COUNT -> all outputs 0 next clk, lfsr_q=16'hACE1.
//    Force lfsr=0 -> lfsr_q=SEED the following clk.

Source files
------------

// File: rtl/lfsr_delay_gen.sv
// lfsr_delay_gen: free-running LFSR draws a random millisecond delay, counts it down, then flags ready
module lfsr_delay_gen #(
  parameter int          TICK_DIV   = 50000,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          MIN_MS     = 1000,
  parameter int          RANGE_BITS = 12,
  parameter int          CNT_W      = 13
) (
  input  logic             MAX10_CLK1_50,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             delay_ready,
  output logic             busy,
  output logic [CNT_W-1:0] delay_ms,
  output logic [15:0]      lfsr_q
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [1:0] IDLE = 2'd0, COUNT = 2'd1, READY = 2'd2;
  logic [1:0] state_q, state_d;
  logic [15:0] lfsr_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, dly_q, dly_d, draw;
  logic tick, load, run;
  assign draw = CNT_W'(MIN_MS) + CNT_W'(lfsr_q[RANGE_BITS-1:0]);
  assign tick = pre_q == PW'(TICK_DIV - 1);
  assign run  = state_q == COUNT && !abort;
  assign load = start && !abort && state_q != COUNT;
  always_comb begin
    lfsr_d  = lfsr_q == '0 ? SEED : {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    pre_d   = load ? '0 : run ? (tick ? '0 : pre_q + 1'b1) : pre_q;
    cnt_d   = load ? draw : (run && tick) ? cnt_q - 1'b1 : cnt_q;
    dly_d   = load ? draw : dly_q;
    state_d = abort ? IDLE : load ? COUNT : (run && tick && cnt_q == CNT_W'(1)) ? READY : state_q;
  end
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      pre_q   <= '0;
      cnt_q   <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
    end
  end
  assign delay_ready = state_q == READY;
  assign busy        = state_q == COUNT;
  assign delay_ms    = dly_q;
endmodule

// File: tb/tb_lfsr_delay_gen.sv
// tb_lfsr_delay_gen: scoreboard bench; a behavioural model pushes expected outputs, a monitor pops and compares
module tb_lfsr_delay_gen;
  localparam int TICK = 4, MIN_MS = 2, RB = 2, CW = 13;
  localparam logic [15:0] SEED = 16'hACE1;
  typedef struct packed {
    logic          rdy;
    logic          bsy;
    logic [CW-1:0] dms;
    logic [15:0]   lf;
  } exp_t;
  logic clk, reset, start, abort, inject_zero;
  logic delay_ready, busy;
  logic [CW-1:0] delay_ms;
  logic [15:0] lfsr_q;
  exp_t q[$];
  int total = 0, bad = 0;
  int m_mode, m_rem, d;
  logic [CW-1:0] m_delay;
  logic [15:0] m_lfsr;

  lfsr_delay_gen #(.TICK_DIV(TICK), .SEED(SEED), .MIN_MS(MIN_MS), .RANGE_BITS(RB), .CNT_W(CW)) dut (
    .MAX10_CLK1_50(clk), .reset(reset), .start(start), .abort(abort),
    .delay_ready(delay_ready), .busy(busy), .delay_ms(delay_ms), .lfsr_q(lfsr_q));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: modes 0=idle 1=counting 2=ready; the delay is a plain countdown of D*TICK clocks
  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_lfsr = SEED; m_delay = '0; m_rem = 0;
    end else begin
      d = MIN_MS + int'(m_lfsr) % (1 << RB);
      if (abort) m_mode = 0;
      else if (start && m_mode != 1) begin
        m_delay = CW'(d); m_rem = d * TICK; m_mode = 1;
      end else if (m_mode == 1) begin
        m_rem--;
        if (m_rem == 0) m_mode = 2;
      end
      m_lfsr = (m_lfsr == 0) ? SEED : {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
      if (inject_zero) m_lfsr = '0;
    end
    q.push_back('{rdy: m_mode == 2, bsy: m_mode == 1, dms: m_delay, lf: m_lfsr});
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("delay_ready", 32'(delay_ready), 32'(e.rdy));
      chk("busy", 32'(busy), 32'(e.bsy));
      chk("delay_ms", 32'(delay_ms), 32'(e.dms));
      chk("lfsr_q", 32'(lfsr_q), 32'(e.lf));
    end
  end

  task automatic pulse_start();
    start = 1; @(negedge clk); start = 0;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!delay_ready && n < budget) begin @(negedge clk); n++; end
    chk("wait_ready_timeout", 32'(delay_ready), 32'd1);
  endtask

  initial begin
    int rise, bcnt, n, hits;
    logic [CW-1:0] saved;
    reset = 1; start = 0; abort = 0; inject_zero = 0;
    repeat (3) @(negedge clk);
    chk("reset_lfsr", 32'(lfsr_q), 32'(SEED));
    chk("reset_outs", {busy, delay_ready, delay_ms}, 0);
    reset = 0;
    repeat (5) @(negedge clk);
    // start when the low LFSR bits give D = 3
    n = 0;
    while (lfsr_q[1:0] != 2'b01 && n < 64) begin @(negedge clk); n++; end
    chk("find_lfsr01", 32'(lfsr_q[1:0]), 32'd1);
    pulse_start();
    chk("delay_ms_3", 32'(delay_ms), 32'd3);
    rise = -1; bcnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (busy) bcnt++;
      if (delay_ready && rise < 0) rise = k;
      @(negedge clk);
    end
    chk("busy_clks", bcnt, 12);
    chk("ready_latency", rise, 12);
    chk("ready_holds", 32'(delay_ready), 32'd1);
    // restart ignored while counting
    abort = 1; @(negedge clk); abort = 0;
    pulse_start();
    saved = delay_ms;
    repeat (5) @(negedge clk);
    pulse_start();
    chk("restart_ignored", 32'(delay_ms), 32'(saved));
    wait_ready(40);
    // abort 5 clocks after start
    abort = 1; @(negedge clk); abort = 0;
    pulse_start();
    saved = delay_ms;
    repeat (4) @(negedge clk);
    abort = 1; @(negedge clk); abort = 0;
    chk("abort_busy", 32'(busy), 32'd0);
    hits = 0;
    repeat (25) begin if (delay_ready) hits++; @(negedge clk); end
    chk("abort_no_ready", hits, 0);
    chk("abort_keeps_dms", 32'(delay_ms), 32'(saved));
    // start+abort together in READY
    pulse_start();
    wait_ready(40);
    saved = delay_ms;
    start = 1; abort = 1; @(negedge clk); start = 0; abort = 0;
    chk("both_ready", 32'(delay_ready), 32'd0);
    chk("both_busy", 32'(busy), 32'd0);
    chk("both_no_reload", 32'(delay_ms), 32'(saved));
    pulse_start();
    chk("restart_busy", 32'(busy), 32'd1);
    // reset mid-count
    repeat (3) @(negedge clk);
    reset = 1; @(negedge clk); reset = 0;
    chk("midreset_outs", {busy, delay_ready, delay_ms}, 0);
    chk("midreset_lfsr", 32'(lfsr_q), 32'(SEED));
    // zero LFSR state recovers to SEED
    repeat (3) @(negedge clk);
    inject_zero = 1;
    @(posedge clk);
    #1 force dut.lfsr_q = 16'h0000;
    #1 release dut.lfsr_q;
    @(negedge clk);
    inject_zero = 0;
    chk("zero_held", 32'(lfsr_q), 32'd0);
    @(negedge clk);
    chk("zero_reload", 32'(lfsr_q), 32'(SEED));
    // randomized traffic
    repeat (400) begin
      start = ($urandom % 8) == 0;
      abort = ($urandom % 25) == 0;
      reset = ($urandom % 100) == 0;
      @(negedge clk);
    end
    start = 0; abort = 0; reset = 0;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
